// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants, state type and header helper for the SD command path
package sd_pkg;

  localparam int         CMD_FRAME_BITS = 48;
  localparam int         CMD_HDR_BITS   = 40;
  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam logic [5:0] CMD55_IDX      = 6'd55;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } tx_state_e;

  // Start bit, transmission bit, index, argument: everything that precedes the CRC.
  function automatic logic [CMD_HDR_BITS-1:0] cmd_header(input logic [5:0]  idx,
                                                         input logic [31:0] arg);
    return {2'b01, idx, arg};
  endfunction

endpackage

// File: rtl/sd_cmd_tx_if.sv
// rtl/sd_cmd_tx_if.sv - command request handshake between SD command FSM and transmitter
interface sd_cmd_tx_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_acmd;
  logic [15:0] rca;

  modport master (output cmd_valid, cmd_idx, cmd_arg, cmd_acmd, rca, input cmd_ready);
  modport slave  (input cmd_valid, cmd_idx, cmd_arg, cmd_acmd, rca, output cmd_ready);

endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1, init 0), one bit per enabled cycle
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = bit_in ^ crc_q[6];
    crc_d = crc_q;
    if (clear) begin
      crc_d = 7'h00;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// rtl/sd_cmd_tx.sv - SD CMD-line token transmitter with optional CMD55 prefix and Ncc gap
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int IDLE_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  sd_cmd_tx_if.slave  req,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cmdn
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int               GAP_W      = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(IDLE_BITS - 1);
  localparam logic [5:0]       LAST_HDR   = 6'(CMD_HDR_BITS - 1);
  localparam logic [5:0]       LAST_BIT   = 6'(CMD_FRAME_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [39:0]       sr_q, sr_d;
  logic              pend_q, pend_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       arg_q, arg_d;
  logic              oe_q, oe_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [7:0]        cmdn_q, cmdn_d;

  logic              accept, tick, load;
  logic [5:0]        load_idx;
  logic [31:0]       load_arg;
  logic              crc_clr, crc_en;
  logic [6:0]        crc;

  assign accept = req.cmd_valid & ready_q;
  assign tick   = (div_q == '0);

  // The CRC sees each header bit on the tick that puts it on the line; the
  // start bit is zero so clearing the CRC already accounts for it.
  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clr),
    .en     (crc_en),
    .bit_in (sr_q[38]),
    .crc    (crc)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? DIV_RELOAD : div_q - DIV_W'(1);
    bit_d    = bit_q;
    gap_d    = gap_q;
    sr_d     = sr_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    oe_d     = oe_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    cmdn_d   = cmdn_q;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    load     = 1'b0;
    load_idx = 6'd0;
    load_arg = 32'd0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        ready_d = 1'b1;
        if (accept) begin
          idx_d    = req.cmd_idx;
          arg_d    = req.cmd_arg;
          pend_d   = req.cmd_acmd;
          load     = 1'b1;
          load_idx = req.cmd_acmd ? CMD55_IDX : req.cmd_idx;
          load_arg = req.cmd_acmd ? {req.rca, 16'h0000} : req.cmd_arg;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          bit_d = bit_q + 6'd1;
          if (bit_q < LAST_HDR) begin
            sr_d   = {sr_q[38:0], 1'b1};
            crc_en = 1'b1;
          end else if (bit_q == LAST_HDR) begin
            sr_d = {crc, 1'b1, 32'hFFFF_FFFF};
          end else begin
            sr_d = {sr_q[38:0], 1'b1};
          end
          if (bit_q == LAST_BIT) begin
            state_d = ST_GAP;
            gap_d   = GAP_RELOAD;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
          end else if (pend_q) begin
            pend_d   = 1'b0;
            load     = 1'b1;
            load_idx = idx_q;
            load_arg = arg_q;
          end else begin
            state_d = ST_DONE;
            oe_d    = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_SHIFT;
      sr_d    = cmd_header(load_idx, load_arg);
      cmdn_d  = {2'b01, load_idx};
      crc_clr = 1'b1;
      bit_d   = 6'd0;
      div_d   = DIV_RELOAD;
      oe_d    = 1'b1;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= 6'd0;
      gap_q   <= '0;
      sr_q    <= '1;
      pend_q  <= 1'b0;
      idx_q   <= 6'd0;
      arg_q   <= 32'd0;
      oe_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cmdn_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sr_q    <= sr_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cmdn_q  <= cmdn_d;
    end
  end

  assign req.cmd_ready = ready_q;
  assign busy          = ~ready_q;
  assign sd_cmd_out    = sr_q[39];
  assign sd_cmd_oe     = oe_q;
  assign done          = done_q;
  assign cmdn          = cmdn_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb/tb_sd_cmd_tx.sv - scoreboard bench for sd_cmd_tx: frames, timing, ACMD, hold-valid, reset
module tb_sd_cmd_tx;
  import sd_pkg::*;

  localparam int DIV  = 4;
  localparam int IDLE = 8;
  localparam int TOK  = (CMD_FRAME_BITS + IDLE) * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       sd_cmd_out, sd_cmd_oe, busy, done;
  logic [7:0] cmdn;

  sd_cmd_tx_if bus ();

  sd_cmd_tx #(.CLK_DIV(DIV), .IDLE_BITS(IDLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .busy       (busy),
    .done       (done),
    .cmdn       (cmdn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;
  int n_acc = 0;
  int exp_acc = 0;

  logic [47:0] q_frame[$];
  logic [7:0]  q_cmdn[$];
  int          q_start[$];
  int          q_done[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    logic [6:0]  c;
    logic        fb;
    h = {2'b01, idx, arg};
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = h[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {h, c, 1'b1};
  endfunction

  task automatic push_expect(input logic [5:0] idx, input logic acmd, input logic [47:0] pre_f,
                             input logic [47:0] main_f, input int acc);
    exp_acc++;
    if (acmd) begin
      q_frame.push_back(pre_f);
      q_cmdn.push_back({2'b01, CMD55_IDX});
      q_start.push_back(acc);
      q_frame.push_back(main_f);
      q_cmdn.push_back({2'b01, idx});
      q_start.push_back(acc + TOK);
      q_done.push_back(acc + 2 * TOK);
    end else begin
      q_frame.push_back(main_f);
      q_cmdn.push_back({2'b01, idx});
      q_start.push_back(acc);
      q_done.push_back(acc + TOK);
    end
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic acmd,
                      input logic [15:0] r, input logic [47:0] pre_f, input logic [47:0] main_f,
                      output int acc);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = idx;
    bus.cmd_arg   = arg;
    bus.cmd_acmd  = acmd;
    bus.rca       = r;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n < 3000, 1'b1);
    acc = cyc + 1;
    push_expect(idx, acmd, pre_f, main_f, acc);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q_done.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", n < 5000, 1'b1);
  endtask

  always @(posedge clk) if (!reset && bus.cmd_valid && bus.cmd_ready) n_acc++;

  int          ms = 0;
  int          fs = 0;
  int          gap = 0;
  logic [47:0] fr;

  task start_frame();
    ms = 1;
    fs = cyc;
    fr = {47'd0, sd_cmd_out};
    if (q_start.size() == 0) check("spurious_frame", 1'b1, 1'b0);
    else begin
      check("start_cycle", cyc, q_start.pop_front());
      check("cmdn", cmdn, q_cmdn.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset) ms = 0;
    else begin
      if (done) begin
        if (q_done.size() == 0) check("spurious_done", 1'b1, 1'b0);
        else check("done_cycle", cyc, q_done.pop_front());
        check("done_oe_low", sd_cmd_oe, 1'b0);
      end
      case (ms)
        0: if (sd_cmd_oe && !sd_cmd_out) start_frame();
        1: begin
          if ((cyc - fs) % DIV == 0) fr = {fr[46:0], sd_cmd_out};
          else check("bit_hold", {sd_cmd_oe, sd_cmd_out}, {1'b1, fr[0]});
          if (cyc - fs == CMD_FRAME_BITS * DIV - 1) begin
            if (q_frame.size() == 0) check("spurious_token", 1'b1, 1'b0);
            else check("frame", fr, q_frame.pop_front());
            ms  = 2;
            gap = 0;
          end
        end
        default: begin
          if (sd_cmd_oe && sd_cmd_out) gap++;
          else begin
            check("gap_len", gap, IDLE * DIV);
            ms = 0;
            if (sd_cmd_oe && !sd_cmd_out) start_frame();
          end
        end
      endcase
    end
  end

  initial begin
    int acc, acc2, n;
    logic [31:0] a;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_idx   = 6'd0;
    bus.cmd_arg   = 32'd0;
    bus.cmd_acmd  = 1'b0;
    bus.rca       = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out", sd_cmd_out, 1'b1);
    check("rst_oe", sd_cmd_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cmdn", cmdn, 8'h00);
    reset = 1'b0;

    send(6'd0, 32'd0, 1'b0, 16'd0, 48'd0, 48'h40_0000_0000_95, acc);
    drain();
    send(6'd8, 32'h0000_01AA, 1'b0, 16'd0, 48'd0, 48'h48_0000_01AA_87, acc);
    drain();
    send(6'd41, 32'd0, 1'b1, 16'h0000, 48'h77_0000_0000_65, frame_of(6'd41, 32'd0), acc);
    drain();

    // Hold valid through a transfer while scrambling the request fields.
    a = $urandom;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = 6'd17;
    bus.cmd_arg   = a;
    bus.cmd_acmd  = 1'b0;
    acc = cyc + 1;
    push_expect(6'd17, 1'b0, 48'd0, frame_of(6'd17, a), acc);
    check("hold_first_ready", bus.cmd_ready, 1'b1);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.cmd_ready || n > 3000) break;
      bus.cmd_idx = 6'($urandom);
      bus.cmd_arg = $urandom;
    end
    check("hold_reaccept_cycle", cyc, acc + TOK);
    acc2 = cyc + 1;
    push_expect(bus.cmd_idx, 1'b0, 48'd0, frame_of(bus.cmd_idx, bus.cmd_arg), acc2);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drain();

    send(6'd24, 32'h1234_5678, 1'b0, 16'd0, 48'd0, frame_of(6'd24, 32'h1234_5678), acc);
    while (cyc < acc + 20 * DIV) @(negedge clk);
    reset = 1'b1;
    q_frame.delete();
    q_cmdn.delete();
    q_start.delete();
    q_done.delete();
    @(negedge clk);
    check("abort_oe", sd_cmd_oe, 1'b0);
    check("abort_out", sd_cmd_out, 1'b1);
    check("abort_ready", bus.cmd_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_cmdn", cmdn, 8'h00);
    check("abort_done", done, 1'b0);
    reset = 1'b0;
    repeat (TOK + 10) @(negedge clk);
    check("abort_idle_oe", sd_cmd_oe, 1'b0);

    send(6'd6, 32'h0000_0002, 1'b1, 16'hABCD, frame_of(CMD55_IDX, {16'hABCD, 16'h0000}),
         frame_of(6'd6, 32'h0000_0002), acc);
    drain();
    repeat (5) @(negedge clk);

    check("accept_count", n_acc, exp_acc);
    check("frames_left", q_frame.size(), 0);
    check("starts_left", q_start.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
